// File: rtl/handshake_responder_2b_pkg.sv
// Package hs_pkg: shared types and defaults for handshake_responder_2b.
//   hs_state_t       - responder FSM state encoding (IDLE / DELIVER / ACK)
//   HS_SYNC_DEFAULT  - default depth of the request synchroniser
package hs_pkg;

    typedef enum logic [1:0] {
        HS_IDLE    = 2'd0,
        HS_DELIVER = 2'd1,
        HS_ACK     = 2'd2
    } hs_state_t;

    localparam int HS_SYNC_DEFAULT = 2;

endpackage

// File: rtl/handshake_responder_2b_sync.sv
// hs_sync: SYNC_STAGES-deep flop chain bringing an asynchronous level into clk.
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous reset, active-high; clears every stage to 0
//   d    in   asynchronous input level
//   q    out  synchronised level (output of the last stage)
module hs_sync
    import hs_pkg::*;
#(
    parameter int SYNC_STAGES = HS_SYNC_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift towards the MSB; bit 0 is the metastability-catching stage.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/handshake_responder_2b.sv
// handshake_responder_2b: clocked receiver for a 4-phase req/ack channel.
// The asynchronous request is synchronised, the bundled sel/data are captured
// once the synchronised request is seen, the word is offered to a consumer on
// a valid/ready port, and ack is returned only after the consumer accepts.
// One wrapping transaction counter is kept per arbiter channel.
//
// Consumer handshake: a word transfers on a rising clk edge where out_valid
// and out_ready are both 1; out_valid, out_sel and out_data stay stable until
// that edge, and out_ready has no effect while out_valid is 0.
//
// Optional feature macro: HS_TIMEOUT_EN (ACK-state timeout with sticky error).
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   req_in        asynchronous request from the arbiter
//   sel_in        channel select, stable while req_in=1
//   data_in       bundled data word, stable while req_in=1
//   ack_out       registered acknowledge back to the arbiter
//   out_valid     captured word available to the consumer
//   out_ready     consumer accepts the word
//   out_sel       channel of the captured word
//   out_data      captured word
//   cnt0, cnt1    completed transactions per channel (wrap)
//   busy          FSM is not IDLE
//   timeout_err   sticky timeout flag (0 unless HS_TIMEOUT_EN)
module handshake_responder_2b
    import hs_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = HS_SYNC_DEFAULT,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_in,
    input  logic              sel_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sel,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic              busy,
    output logic              timeout_err
);

    logic req_s;

    hs_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_req_sync (
        .clk(clk),
        .rst(rst),
        .d  (req_in),
        .q  (req_s)
    );

    hs_state_t         state_q,     state_d;
    logic              out_valid_q, out_valid_d;
    logic              ack_q,       ack_d;
    logic              out_sel_q,   out_sel_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [CNT_W-1:0]  cnt0_q,      cnt0_d;
    logic [CNT_W-1:0]  cnt1_q,      cnt1_d;
    logic              capture_ok;

`ifdef HS_TIMEOUT_EN
    localparam int             TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_err_q, tmo_err_d;
    logic             armed_q,   armed_d;

    // After a timeout the request still reads high; a fresh capture must wait
    // until the request has been seen low again.
    assign capture_ok = armed_q;
`else
    assign capture_ok = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        ack_d       = ack_q;
        out_sel_d   = out_sel_q;
        out_data_d  = out_data_q;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;
`ifdef HS_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        tmo_err_d   = tmo_err_q;
        armed_d     = armed_q;
        if (!req_s) begin
            armed_d = 1'b1;
        end
`endif

        case (state_q)
            HS_IDLE: begin
                // Bundled data is settled by the time req_s rises.
                if (req_s && capture_ok) begin
                    out_sel_d   = sel_in;
                    out_data_d  = data_in;
                    out_valid_d = 1'b1;
                    state_d     = HS_DELIVER;
                end
            end

            HS_DELIVER: begin
                // A req_s drop here is a protocol violation and is ignored:
                // the word is still delivered and acknowledged.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    ack_d       = 1'b1;
                    state_d     = HS_ACK;
                    if (out_sel_q) begin
                        cnt1_d = cnt1_q + CNT_W'(1);
                    end else begin
                        cnt0_d = cnt0_q + CNT_W'(1);
                    end
`ifdef HS_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end

            HS_ACK: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = HS_IDLE;
                end
`ifdef HS_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_err_d = 1'b1;
                    ack_d     = 1'b0;
                    armed_d   = 1'b0;
                    state_d   = HS_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`endif
            end

            default: begin
                state_d     = HS_IDLE;
                out_valid_d = 1'b0;
                ack_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HS_IDLE;
            out_valid_q <= 1'b0;
            ack_q       <= 1'b0;
            out_sel_q   <= 1'b0;
            out_data_q  <= '0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            ack_q       <= ack_d;
            out_sel_q   <= out_sel_d;
            out_data_q  <= out_data_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
        end
    end

`ifdef HS_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
            armed_q   <= 1'b1;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
            armed_q   <= armed_d;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign ack_out   = ack_q;
    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;
    assign out_data  = out_data_q;
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;
    assign busy      = (state_q != HS_IDLE);

endmodule

// File: tb/tb_handshake_responder_2b.sv
// Bench for handshake_responder_2b (DATA_W=8, SYNC_STAGES=2, CNT_W=8,
// TIMEOUT_CYC=16). Stimulus pushes each expected {sel,data} word into exp_q;
// a negedge monitor pops and compares on every accepted word. Directed checks
// cover reset, edge-exact latency, stall, counter wrap and mid-flight reset.
module tb_handshake_responder_2b;

    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 8;
    localparam int TIMEOUT_CYC = 16;
    localparam int SIG_VALID   = 0;
    localparam int SIG_ACK     = 1;

    logic              clk;
    logic              rst;
    logic              req_in;
    logic              sel_in;
    logic [DATA_W-1:0] data_in;
    logic              ack_out;
    logic              out_valid;
    logic              out_ready;
    logic              out_sel;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  cnt0;
    logic [CNT_W-1:0]  cnt1;
    logic              busy;
    logic              timeout_err;

    logic [DATA_W:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    handshake_responder_2b #(
        .DATA_W     (DATA_W),
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_W      (CNT_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req_in),
        .sel_in     (sel_in),
        .data_in    (data_in),
        .ack_out    (ack_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sel    (out_sel),
        .out_data   (out_data),
        .cnt0       (cnt0),
        .cnt1       (cnt1),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic sig_of(input int which);
        return (which == SIG_VALID) ? out_valid : ack_out;
    endfunction

    // Bounded wait; an expired budget counts as a failed comparison.
    task automatic wait_for(input int which, input logic val, input int budget, input string name);
        int n = 0;
        while (sig_of(which) !== val && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (sig_of(which) !== val) begin
            failures++;
            $display("FAIL %s: actual=%b required=%b after %0d cycles", name, sig_of(which), val, n);
        end
    endtask

    // One complete 4-phase transaction with an always-ready consumer.
    task automatic run_txn(input logic s, input logic [DATA_W-1:0] d);
        req_in  = 1'b1;
        sel_in  = s;
        data_in = d;
        exp_q.push_back({s, d});
        wait_for(SIG_VALID, 1'b1, 10, "txn_valid");
        out_ready = 1'b1;
        wait_for(SIG_ACK, 1'b1, 10, "txn_ack_rise");
        req_in = 1'b0;
        wait_for(SIG_ACK, 1'b0, 10, "txn_ack_fall");
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_word: actual=%0h required=<no word expected>", {out_sel, out_data});
            end else begin
                logic [DATA_W:0] e;
                e = exp_q.pop_front();
                if ({out_sel, out_data} !== e) begin
                    failures++;
                    $display("FAIL sb_word: actual=%0h required=%0h", {out_sel, out_data}, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [CNT_W-1:0] c0_before;
        logic [CNT_W-1:0] sum_before;

        rst       = 1'b1;
        req_in    = 1'b0;
        sel_in    = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_ack", ack_out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        chk("rst_data", out_data, 0);
        rst = 1'b0;
        tick();

        // out_ready high in IDLE does nothing
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("idle_ready_valid", out_valid, 0);
        chk("idle_ready_busy", busy, 0);
        chk("idle_ready_cnt0", cnt0, 0);

        // Test 1: edge-exact latency
        req_in  = 1'b1;
        sel_in  = 1'b0;
        data_in = 8'hA5;
        exp_q.push_back({1'b0, 8'hA5});
        tick();
        chk("t1_valid_e1", out_valid, 0);
        tick();
        chk("t1_valid_e2", out_valid, 0);
        tick();
        chk("t1_valid_e3", out_valid, 1);
        chk("t1_data_e3", out_data, 8'hA5);
        chk("t1_ack_e3", ack_out, 0);
        tick();
        chk("t1_ack_e4", ack_out, 1);
        chk("t1_valid_e4", out_valid, 0);
        req_in = 1'b0;
        tick();
        chk("t1_ack_fall_e1", ack_out, 1);
        tick();
        chk("t1_ack_fall_e2", ack_out, 1);
        tick();
        chk("t1_ack_fall_e3", ack_out, 0);
        chk("t1_busy_end", busy, 0);
        chk("t1_cnt0", cnt0, 1);

        // Test 2: arbiter grants ch0 then ch1, back to back
        sum_before = cnt0 + cnt1;
        run_txn(1'b0, 8'h3C);
        run_txn(1'b1, 8'hC3);
        chk("t2_cnt_sum", CNT_W'(cnt0 + cnt1), CNT_W'(sum_before + 2));
        chk("t2_cnt1", cnt1, 1);

        // Test 3: consumer stall; late sel/data changes ignored
        out_ready = 1'b0;
        req_in    = 1'b1;
        sel_in    = 1'b1;
        data_in   = 8'h77;
        exp_q.push_back({1'b1, 8'h77});
        wait_for(SIG_VALID, 1'b1, 10, "t3_valid");
        data_in = 8'hFF;
        sel_in  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_stall_valid", out_valid, 1);
            chk("t3_stall_ack", ack_out, 0);
            chk("t3_stall_data", {out_sel, out_data}, {1'b1, 8'h77});
        end
        out_ready = 1'b1;
        tick();
        chk("t3_accept_ack", ack_out, 1);
        chk("t3_accept_valid", out_valid, 0);
        chk("t3_cnt1", cnt1, 2);
        req_in = 1'b0;
        wait_for(SIG_ACK, 1'b0, 10, "t3_ack_fall");

        // Test 5: reset during ACK, request still high afterwards
        req_in  = 1'b1;
        sel_in  = 1'b0;
        data_in = 8'h96;
        exp_q.push_back({1'b0, 8'h96});
        wait_for(SIG_VALID, 1'b1, 10, "t5_valid");
        wait_for(SIG_ACK, 1'b1, 10, "t5_ack");
        rst = 1'b1;
        #1;
        chk("t5_rst_ack", ack_out, 0);
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_cnt0", cnt0, 0);
        sel_in  = 1'b1;
        data_in = 8'h5A;
        exp_q.push_back({1'b1, 8'h5A});
        tick();
        rst = 1'b0;
        wait_for(SIG_VALID, 1'b1, 10, "t5_recapture");
        wait_for(SIG_ACK, 1'b1, 10, "t5_re_ack");
        req_in = 1'b0;
        wait_for(SIG_ACK, 1'b0, 10, "t5_re_ack_fall");
        chk("t5_cnt1", cnt1, 1);

        // Test 4: 256 transactions on channel 1 wrap the counter
        pulse_reset();
        chk("t4_cnt1_start", cnt1, 0);
        c0_before = cnt0;
        for (int i = 0; i < 256; i++) begin
            run_txn(1'b1, 8'(i));
            if (i == 254) chk("t4_cnt1_255", cnt1, 255);
        end
        chk("t4_cnt1_wrap", cnt1, 0);
        chk("t4_cnt0_same", cnt0, c0_before);

`ifdef HS_TIMEOUT_EN
        // Test 6: request held high after ack -> timeout, no recapture until re-armed
        pulse_reset();
        req_in  = 1'b1;
        sel_in  = 1'b0;
        data_in = 8'h11;
        exp_q.push_back({1'b0, 8'h11});
        wait_for(SIG_VALID, 1'b1, 10, "t6_valid");
        wait_for(SIG_ACK, 1'b1, 10, "t6_ack");
        wait_for(SIG_ACK, 1'b0, TIMEOUT_CYC + 4, "t6_timeout_ack");
        chk("t6_timeout_err", timeout_err, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t6_no_recapture", out_valid, 0);
        end
        req_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        run_txn(1'b1, 8'h22);
        chk("t6_err_sticky", timeout_err, 1);
`else
        chk("no_timeout_err", timeout_err, 0);
`endif

        for (int i = 0; i < 4; i++) tick();
        chk("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
